core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32 core: fetches from instruction memory, holds the instruction for the combinational decoder, reads the register file, executes ADD/ADDI and the six conditional branches, writes back, and advances the PC. Decoder flags drive the FSM. Illegal, unsupported or misaligned-target instructions park the core in a sticky trap state.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
run_en  in  1  allow new fetches; sampled only when entering or holding in FETCH with imem_req low
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address, equals pc while imem_req high
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register, feeds decoder
dec_incorrect  in  1  decoder illegal-encoding flag
dec_is_add, dec_is_addi, dec_is_beq, dec_is_bne, dec_is_blt, dec_is_bge, dec_is_bltu, dec_is_bgeu  in  1 each  decoder op flags
dec_rd  in  5  decoded destination register
dec_imm  in  32  decoded immediate
rs1_data  in  32  register file read port 1 (combinational read)
rs2_data  in  32  register file read port 2
rf_we  out  1  register write strobe, one cycle
rf_waddr  out  5  write address
rf_wdata  out  32  write data
pc  out  32  architectural PC
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky trap indicator
trap_cause  out  2  01 illegal, 10 unsupported, 11 misaligned branch target

Behaviour:
- Reset (async, rst_n low): state FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, trap=0, trap_cause=0. Asserting reset mid-handshake drops imem_req immediately; any in-flight ack is ignored.
- FETCH: if imem_req=0 and run_en=1, raise imem_req next cycle. Once raised, imem_req stays high regardless of run_en until imem_ack=1. On ack: instr<=imem_rdata, imem_req<=0, go DECODE. imem_ack while imem_req=0 is ignored. Minimum one wait cycle after req rises (ack in the cycle after req rises gives the fastest fetch).
- DECODE (1 cycle): latch rs1_data, rs2_data, dec_imm, dec_rd and op flags into operand registers. If dec_incorrect, go TRAP with cause 01. Else, if no supported flag is set, go TRAP with cause 10. Else go EXEC.
- EXEC (1 cycle):
  - ADD: result=rs1+rs2, mod 2^32.
  - ADDI: result=rs1+imm.
  - Branches: compare in branch_unit. BLT/BGE are signed; BLTU/BGEU are unsigned.
  - Taken target = pc+imm. Not-taken next_pc = pc+4. Both wrap mod 2^32.
  - If taken and target[1]=1, go TRAP with cause 11. Otherwise go WB.
- WB (1 cycle):
  - ADD/ADDI: rf_we=1, rf_waddr=rd, rf_wdata=result; rf_we is suppressed when rd=0.
  - pc<=next_pc, retire=1 for this cycle, go FETCH.
- Minimum latency is 5 cycles per instruction: req, ack, DECODE, EXEC, WB.
- TRAP: trap=1, trap_cause held, pc frozen at the faulting instruction, imem_req=0, rf_we=0. Exit only by reset. No retire for the trapping instruction.
- rf_we and retire are registered and never high outside WB.

Decomposition:
- core_pkg holds:
  - enum ctrl_state_t {FETCH, DECODE, EXEC, WB, TRAP}
  - trap cause constants CAUSE_ILLEGAL=2'b01, CAUSE_UNSUPP=2'b10, CAUSE_MISALIGN=2'b11
  - PC_STEP=32'd4
- Sub-module branch_unit (combinational): inputs are the op flags and two 32-bit operands; output is taken.

Test Plan:
- Reset then run_en=1, ack 2 cycles after req, imem_rdata=32'h00500093 (addi x1,x0,5) -> imem_addr=0; rf_we pulse with waddr=1, wdata=5; retire pulse; pc=4; next imem_addr=4.
- add x3,x1,x2 (32'h002081B3) with rs1=32'hFFFF_FFFF, rs2=2 -> wdata=1 (wrap); addi x0,x0,7 -> retire=1, rf_we stays 0.
- blt with rs1=32'hFFFF_FFFF, rs2=1, imm=8 at pc=16 -> taken, pc=24. Same operands with bltu -> not taken, pc=20.
- instr=32'h0000_0000 -> trap=1, cause=01, pc unchanged, no further imem_req. lui (32'h000010B7) -> cause=10.
- beq taken with imm=6 -> cause=11, rf_we never asserted.
- rst_n pulsed low while imem_req=1 -> imem_req=0 asynchronously; ack arriving during reset ignored; after release, refetch from RESET_PC. run_en=0 in FETCH -> imem_req stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 multi-cycle sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    TRAP   = 3'd4
  } ctrl_state_t;

  localparam logic [1:0]  CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0]  CAUSE_UNSUPP   = 2'b10;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b11;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Decoder op flags, one-hot in practice.
  typedef struct packed {
    logic add;
    logic addi;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
  } op_flags_t;

  // True when the decoder flagged any operation this core executes.
  function automatic logic op_supported(input op_flags_t f);
    return |f;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-memory fetch handshake.
interface core_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/branch_unit.sv
// Combinational branch-condition evaluation for the six conditional branches.
module branch_unit (
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        blt_i,
  input  logic        bge_i,
  input  logic        bltu_i,
  input  logic        bgeu_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  // Resolve the selected condition from one equality and two magnitude compares.
  always_comb begin
    eq      = (a_i == b_i);
    lt_s    = ($signed(a_i) < $signed(b_i));
    lt_u    = (a_i < b_i);
    taken_o = (beq_i  &  eq)   |
              (bne_i  & ~eq)   |
              (blt_i  &  lt_s) |
              (bge_i  & ~lt_s) |
              (bltu_i &  lt_u) |
              (bgeu_i & ~lt_u);
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32 sequencer: fetch, decode, execute ADD/ADDI/branches, write back.
//
//   state  | meaning
//   FETCH  | request instruction word, wait for ack
//   DECODE | latch operands and decoder flags, screen illegal/unsupported
//   EXEC   | compute ALU result and branch target, screen misaligned target
//   WB     | register write strobe, retire pulse, advance pc
//   TRAP   | sticky fault, exit only by reset
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_en,
  core_seq_ctrl_if.master        imem,
  output logic [31:0]            instr,
  input  logic                   dec_incorrect,
  input  logic                   dec_is_add,
  input  logic                   dec_is_addi,
  input  logic                   dec_is_beq,
  input  logic                   dec_is_bne,
  input  logic                   dec_is_blt,
  input  logic                   dec_is_bge,
  input  logic                   dec_is_bltu,
  input  logic                   dec_is_bgeu,
  input  logic [4:0]             dec_rd,
  input  logic [31:0]            dec_imm,
  input  logic [31:0]            rs1_data,
  input  logic [31:0]            rs2_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [31:0]            pc,
  output logic                   retire,
  output logic                   trap,
  output logic [1:0]             trap_cause
);

  ctrl_state_t state_q, state_d;

  op_flags_t   dec_ops;
  op_flags_t   ops_q;
  logic [31:0] pc_q, next_pc_q, instr_q;
  logic [31:0] rs1_q, rs2_q, imm_q;
  logic [4:0]  rd_q;
  logic        imem_req_q, imem_req_d;
  logic        rf_we_q, retire_q, trap_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [1:0]  trap_cause_q, cause_d;

  logic        ld_instr, ld_ops, wb_go, pc_adv, trap_go;
  logic        taken, misalign;
  logic [31:0] alu_res, br_target, seq_pc, next_pc;

  assign dec_ops = '{add:  dec_is_add,  addi: dec_is_addi,
                     beq:  dec_is_beq,  bne:  dec_is_bne,
                     blt:  dec_is_blt,  bge:  dec_is_bge,
                     bltu: dec_is_bltu, bgeu: dec_is_bgeu};

  branch_unit u_branch (
    .beq_i   (ops_q.beq),
    .bne_i   (ops_q.bne),
    .blt_i   (ops_q.blt),
    .bge_i   (ops_q.bge),
    .bltu_i  (ops_q.bltu),
    .bgeu_i  (ops_q.bgeu),
    .a_i     (rs1_q),
    .b_i     (rs2_q),
    .taken_o (taken)
  );

  // Execute-stage datapath: ALU sum, branch target and the pc that WB will commit.
  always_comb begin
    alu_res   = rs1_q + (ops_q.add ? rs2_q : imm_q);
    br_target = pc_q + imm_q;
    seq_pc    = pc_q + PC_STEP;
    next_pc   = taken ? br_target : seq_pc;
    misalign  = taken & br_target[1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imem_req_q && imem.imem_ack) state_d = DECODE;
      DECODE:  if (dec_incorrect || !op_supported(dec_ops)) state_d = TRAP;
               else                                         state_d = EXEC;
      EXEC:    state_d = misalign ? TRAP : WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Per-state control strobes for the datapath registers.
  always_comb begin
    imem_req_d = imem_req_q;
    ld_instr   = 1'b0;
    ld_ops     = 1'b0;
    wb_go      = 1'b0;
    pc_adv     = 1'b0;
    trap_go    = 1'b0;
    cause_d    = CAUSE_NONE;
    case (state_q)
      FETCH: begin
        // Once raised, the request is held until ack; run_en only gates raising it.
        if (imem_req_q) begin
          if (imem.imem_ack) begin
            imem_req_d = 1'b0;
            ld_instr   = 1'b1;
          end
        end else begin
          imem_req_d = run_en;
        end
      end
      DECODE: begin
        ld_ops = 1'b1;
        if (dec_incorrect) begin
          trap_go = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else if (!op_supported(dec_ops)) begin
          trap_go = 1'b1;
          cause_d = CAUSE_UNSUPP;
        end
      end
      EXEC: begin
        if (misalign) begin
          trap_go = 1'b1;
          cause_d = CAUSE_MISALIGN;
        end else begin
          wb_go = 1'b1;
        end
      end
      WB: begin
        // Entering FETCH: launch the next request straight away so back-to-back
        // instructions take five cycles.
        pc_adv     = 1'b1;
        imem_req_d = run_en;
      end
      TRAP:    imem_req_d = 1'b0;
      default: imem_req_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      next_pc_q    <= RESET_PC;
      instr_q      <= '0;
      imem_req_q   <= 1'b0;
      ops_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      retire_q     <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      imem_req_q <= imem_req_d;
      if (ld_instr) instr_q <= imem.imem_rdata;
      if (ld_ops) begin
        ops_q <= dec_ops;
        rs1_q <= rs1_data;
        rs2_q <= rs2_data;
        imm_q <= dec_imm;
        rd_q  <= dec_rd;
      end
      // Strobes are set on the EXEC->WB edge so they are high exactly during WB.
      rf_we_q  <= wb_go & (ops_q.add | ops_q.addi) & (rd_q != 5'd0);
      retire_q <= wb_go;
      if (wb_go) next_pc_q <= next_pc;
      if (wb_go && (ops_q.add || ops_q.addi)) begin
        rf_waddr_q <= rd_q;
        rf_wdata_q <= alu_res;
      end
      if (pc_adv) pc_q <= next_pc_q;
      if (trap_go) begin
        trap_q       <= 1'b1;
        trap_cause_q <= cause_d;
      end
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign pc             = pc_q;
  assign retire         = retire_q;
  assign trap           = trap_q;
  assign trap_cause     = trap_cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl; the bench plays both memory and decoder.
module tb_core_seq_ctrl;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h80;
  localparam logic [7:0] OP_ADDI = 8'h40;
  localparam logic [7:0] OP_BEQ  = 8'h20;
  localparam logic [7:0] OP_BNE  = 8'h10;
  localparam logic [7:0] OP_BLT  = 8'h08;
  localparam logic [7:0] OP_BGE  = 8'h04;
  localparam logic [7:0] OP_BLTU = 8'h02;
  localparam logic [7:0] OP_BGEU = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic [31:0] instr;
  logic        dec_incorrect = 1'b0;
  logic        dec_is_add = 1'b0, dec_is_addi = 1'b0, dec_is_beq = 1'b0, dec_is_bne = 1'b0;
  logic        dec_is_blt = 1'b0, dec_is_bge = 1'b0, dec_is_bltu = 1'b0, dec_is_bgeu = 1'b0;
  logic [4:0]  dec_rd = '0;
  logic [31:0] dec_imm = '0, rs1_data = '0, rs2_data = '0;
  logic        rf_we, retire, trap;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pc;
  logic [1:0]  trap_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_seq_ctrl_if bus ();

  core_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .imem(bus.master), .instr(instr),
    .dec_incorrect(dec_incorrect),
    .dec_is_add(dec_is_add), .dec_is_addi(dec_is_addi), .dec_is_beq(dec_is_beq),
    .dec_is_bne(dec_is_bne), .dec_is_blt(dec_is_blt), .dec_is_bge(dec_is_bge),
    .dec_is_bltu(dec_is_bltu), .dec_is_bgeu(dec_is_bgeu),
    .dec_rd(dec_rd), .dec_imm(dec_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_dec(input logic [7:0] ops, input logic inc, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
    {dec_is_add, dec_is_addi, dec_is_beq, dec_is_bne,
     dec_is_blt, dec_is_bge, dec_is_bltu, dec_is_bgeu} = ops;
    dec_incorrect = inc;
    dec_rd   = rd;
    dec_imm  = imm;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) break;
      @(negedge clk);
    end
    check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
  endtask

  // One fetch with one wait cycle, then watch EXEC, WB and the following FETCH cycle.
  task automatic do_instr(input string tag, input logic [31:0] word, input logic [31:0] exp_addr,
                          output logic we_seen, output logic [4:0] wa, output logic [31:0] wd,
                          output int ret_cnt);
    wait_req(tag);
    check({tag, "_addr"}, bus.imem_addr, exp_addr);
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    check({tag, "_instr"}, instr, word);
    we_seen = 1'b0;
    wa      = '0;
    wd      = '0;
    ret_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_we) begin
        we_seen = 1'b1;
        wa      = rf_waddr;
        wd      = rf_wdata;
      end
      if (retire) ret_cnt++;
    end
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    logic req_seen = 1'b0;
    logic act_seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.imem_req) req_seen = 1'b1;
      if (rf_we || retire) act_seen = 1'b1;
    end
    check({tag, "_no_req"}, {31'd0, req_seen}, 32'd0);
    check({tag, "_no_act"}, {31'd0, act_seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          rc;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // Reset state
    do_reset();
    #1;
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr",  bus.imem_addr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_we",    {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'h0);
    check("rst_ret",   {31'd0, retire}, 32'd0);
    check("rst_trap",  {29'd0, trap, trap_cause}, 32'd0);

    run_en = 1'b1;
    // addi x1,x0,5
    set_dec(OP_ADDI, 1'b0, 5'd1, 32'd5, 32'd0, 32'd0);
    do_instr("addi1", 32'h0050_0093, 32'h0, we, wa, wd, rc);
    check("addi1_we", {31'd0, we}, 32'd1);
    check("addi1_wa", {27'd0, wa}, 32'd1);
    check("addi1_wd", wd, 32'd5);
    check("addi1_ret", rc, 32'd1);
    check("addi1_pc", pc, 32'd4);
    check("addi1_next_req", {31'd0, bus.imem_req}, 32'd1);
    check("addi1_next_addr", bus.imem_addr, 32'd4);

    // add x3,x1,x2 with wrap
    set_dec(OP_ADD, 1'b0, 5'd3, 32'd0, 32'hFFFF_FFFF, 32'd2);
    do_instr("add", 32'h0020_81B3, 32'd4, we, wa, wd, rc);
    check("add_we", {31'd0, we}, 32'd1);
    check("add_wa", {27'd0, wa}, 32'd3);
    check("add_wd", wd, 32'd1);
    check("add_pc", pc, 32'd8);

    // addi x0,x0,7: retires without a write
    set_dec(OP_ADDI, 1'b0, 5'd0, 32'd7, 32'd0, 32'd0);
    do_instr("addi0", 32'h0070_0013, 32'd8, we, wa, wd, rc);
    check("addi0_we", {31'd0, we}, 32'd0);
    check("addi0_ret", rc, 32'd1);
    check("addi0_pc", pc, 32'd12);

    // addi x2,x0,3 to reach pc=16
    set_dec(OP_ADDI, 1'b0, 5'd2, 32'd3, 32'd0, 32'd0);
    do_instr("addi2", 32'h0030_0113, 32'd12, we, wa, wd, rc);
    check("addi2_wd", wd, 32'd3);
    check("addi2_pc", pc, 32'd16);

    // blt -1 < 1 signed: taken to 16+8
    set_dec(OP_BLT, 1'b0, 5'd0, 32'd8, 32'hFFFF_FFFF, 32'd1);
    do_instr("blt", 32'h0020_C463, 32'd16, we, wa, wd, rc);
    check("blt_we", {31'd0, we}, 32'd0);
    check("blt_ret", rc, 32'd1);
    check("blt_pc", pc, 32'd24);

    // bltu 0xFFFFFFFF < 1 unsigned: not taken
    set_dec(OP_BLTU, 1'b0, 5'd0, 32'd8, 32'hFFFF_FFFF, 32'd1);
    do_instr("bltu", 32'h0020_E463, 32'd24, we, wa, wd, rc);
    check("bltu_pc", pc, 32'd28);

    // bge -1 >= 1 signed: not taken
    set_dec(OP_BGE, 1'b0, 5'd0, 32'd8, 32'hFFFF_FFFF, 32'd1);
    do_instr("bge", 32'h0020_D463, 32'd28, we, wa, wd, rc);
    check("bge_pc", pc, 32'd32);

    // bgeu 0xFFFFFFFF >= 1 unsigned: taken backwards by 8
    set_dec(OP_BGEU, 1'b0, 5'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1);
    do_instr("bgeu", 32'hFE20_FCE3, 32'd32, we, wa, wd, rc);
    check("bgeu_pc", pc, 32'd24);

    // bne on equal operands: not taken
    set_dec(OP_BNE, 1'b0, 5'd0, 32'd100, 32'd5, 32'd5);
    do_instr("bne", 32'h0620_9263, 32'd24, we, wa, wd, rc);
    check("bne_pc", pc, 32'd28);

    // beq taken to 28+6=34 (bit1 set): misaligned trap
    set_dec(OP_BEQ, 1'b0, 5'd0, 32'd6, 32'd7, 32'd7);
    do_instr("beqmis", 32'h0020_8363, 32'd28, we, wa, wd, rc);
    check("beqmis_we", {31'd0, we}, 32'd0);
    check("beqmis_ret", rc, 32'd0);
    check("beqmis_trap", {31'd0, trap}, 32'd1);
    check("beqmis_cause", {30'd0, trap_cause}, 32'd3);
    check("beqmis_pc", pc, 32'd28);
    watch_idle("beqmis", 6);

    // Illegal encoding
    do_reset();
    #1;
    check("rst2_trap", {29'd0, trap, trap_cause}, 32'd0);
    set_dec(OP_NONE, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0);
    do_instr("ill", 32'h0000_0000, 32'd0, we, wa, wd, rc);
    check("ill_trap", {31'd0, trap}, 32'd1);
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    check("ill_pc", pc, 32'd0);
    check("ill_ret", rc, 32'd0);
    watch_idle("ill", 6);

    // Unsupported (lui)
    do_reset();
    set_dec(OP_NONE, 1'b0, 5'd1, 32'h0000_1000, 32'd0, 32'd0);
    do_instr("lui", 32'h0000_10B7, 32'd0, we, wa, wd, rc);
    check("lui_trap", {31'd0, trap}, 32'd1);
    check("lui_cause", {30'd0, trap_cause}, 32'd2);
    check("lui_we", {31'd0, we}, 32'd0);
    check("lui_pc", pc, 32'd0);

    // Reset asserted mid-handshake; ack during reset is ignored
    do_reset();
    wait_req("abort");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_req_async", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.imem_ack = 1'b0;
    #1;
    check("abort_instr", instr, 32'h0);
    check("abort_req_rel", {31'd0, bus.imem_req}, 32'd0);
    set_dec(OP_ADDI, 1'b0, 5'd1, 32'd5, 32'd0, 32'd0);
    do_instr("refetch", 32'h0050_0093, 32'd0, we, wa, wd, rc);
    check("refetch_wd", wd, 32'd5);
    check("refetch_pc", pc, 32'd4);

    // run_en dropped after req rises: req held until ack, then no new fetch
    wait_req("hold");
    run_en = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_pc", pc, 32'd8);
    watch_idle("hold_stop", 6);

    // run_en=0 from reset: no fetch
    do_reset();
    watch_idle("runoff", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
